// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares the Load and Store memory-transfer FSMs, and their MAR/MDR/memory
// path, between two requesters:
//   requester 0 = fetch unit
//   requester 1 = execute unit
//
// Operation
//   - One requester is granted at a time. Simultaneous requests are resolved
//     round-robin.
//   - The owner's register selects are latched and forwarded to both FSMs.
//   - A one-cycle start pulse goes to the Load FSM or the Store FSM.
//   - The arbiter waits for that FSM's done, then returns a one-cycle ack to
//     the owner.
//
// All outputs decode from registered state only (Moore). There is no
// combinational path from any input to any output.
//
// Optional feature (macro MEM_TIMEOUT_EN)
//   - A WAIT-state watchdog aborts a transfer after TIMEOUT cycles without
//     done.
//   - The abort is reported as an ack with err=1 in the same cycle.
//   - When the macro is undefined, WAIT holds until done and err is tied 0.
//
// Parameters
//   REG_W    width of the Ri/Rj register-select fields
//   TIMEOUT  WAIT cycles before abort (MEM_TIMEOUT_EN only), 2..2**TO_W-1
//   TO_W     width of the timeout counter
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   req0/we0/ri0/rj0         requester 0: request, store(1)/load(0), Ri, Rj
//   req1/we1/ri1/rj1         requester 1: same fields
//   load_done, store_done    done pulses from the Load / Store FSMs
//   load_start, store_start  one-cycle start pulses to the Load / Store FSMs
//   Ri, Rj                   latched register selects of the current owner
//   ack0, ack1               one-cycle completion pulses to each requester
//   owner                    index of the current owner (valid while busy)
//   busy                     high in every state except IDLE
//   err                      timeout flag, coincident with the ack
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int REG_W   = 6,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [REG_W-1:0] ri0,
  input  logic [REG_W-1:0] rj0,
  input  logic             req1,
  input  logic             we1,
  input  logic [REG_W-1:0] ri1,
  input  logic [REG_W-1:0] rj1,
  input  logic             load_done,
  input  logic             store_done,
  output logic             load_start,
  output logic             store_start,
  output logic [REG_W-1:0] Ri,
  output logic [REG_W-1:0] Rj,
  output logic             ack0,
  output logic             ack1,
  output logic             owner,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Reject a TIMEOUT the counter cannot reach, or one too short to be useful.
  if (TIMEOUT < 2 || TIMEOUT > (2**TO_W) - 1) begin : g_bad_timeout
    $error("mem_access_arbiter: TIMEOUT out of range for TO_W");
  end

  state_t           state;
  state_t           state_nx;
  logic             rr_ptr;
  logic             owner_q;
  logic             we_q;
  logic [REG_W-1:0] ri_q;
  logic [REG_W-1:0] rj_q;
  logic             any_req;
  logic             grant_id;
  logic             sel_done;
  logic             timeout_hit;
  logic             err_q;

  assign any_req = req0 | req1;

  // With only one request pending, that request wins; with both pending,
  // the round-robin pointer decides.
  assign grant_id = (req0 && req1) ? rr_ptr : req1;

  // Only the done of the FSM that was actually started may end WAIT.
  assign sel_done = we_q ? store_done : load_done;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1)) && !sel_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        START: begin
          to_cnt <= '0;
          err_q  <= 1'b0;
        end
        WAIT: begin
          if (timeout_hit) err_q  <= 1'b1;
          else             to_cnt <= to_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks. Every register samples
    // pre-edge values, so results never depend on block evaluation order.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    // NOTE: every signal driven here is given a default first. That way no
    // path through the case statement leaves one unassigned and infers a
    // latch.
    state_nx    = state;
    load_start  = 1'b0;
    store_start = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    err         = 1'b0;
    busy        = (state != IDLE);

    case (state)
      IDLE: begin
        if (any_req) state_nx = START;
      end
      START: begin
        store_start = we_q;
        load_start  = ~we_q;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (sel_done || timeout_hit) state_nx = ACK;
      end
      ACK: begin
        ack0     = ~owner_q;
        ack1     = owner_q;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant latches and round-robin pointer. The latches change only on a
  // grant, so Ri/Rj stay stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      ri_q    <= '0;
      rj_q    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner_q <= grant_id;
        we_q    <= grant_id ? we1 : we0;
        ri_q    <= grant_id ? ri1 : ri0;
        rj_q    <= grant_id ? rj1 : rj0;
      end
      if (state == ACK) rr_ptr <= ~owner_q;
    end
  end

  assign Ri    = ri_q;
  assign Rj    = rj_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_arbiter
//
// Directed bench for mem_access_arbiter.
//
// Transaction model
//   The model tracks the current transfer as a single record: owner, op,
//   register selects, and the age in cycles since the grant.
//   Expected outputs are derived from that record:
//     - a start pulse at age 0
//     - an ack in the cycle after the matching done
//     - an abort at age TIMEOUT (macro build only)
//   A compare process checks every output on each falling edge.
//
// Directed checks
//   Directed sequences drive the requesters, and play the role of the Load and
//   Store FSMs. They also pin the model with hand-computed literal
//   expectations.
// -----------------------------------------------------------------------------
module tb_mem_access_arbiter;

  localparam int REG_W      = 6;
  localparam int TB_TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, we0, req1, we1;
  logic [REG_W-1:0] ri0, rj0, ri1, rj1;
  logic             load_done, store_done;
  logic             load_start, store_start;
  logic [REG_W-1:0] Ri, Rj;
  logic             ack0, ack1, owner, busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .REG_W  (REG_W),
    .TIMEOUT(TB_TIMEOUT),
    .TO_W   (7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .we0        (we0),
    .ri0        (ri0),
    .rj0        (rj0),
    .req1       (req1),
    .we1        (we1),
    .ri1        (ri1),
    .rj1        (rj1),
    .load_done  (load_done),
    .store_done (store_done),
    .load_start (load_start),
    .store_start(store_start),
    .Ri         (Ri),
    .Rj         (Rj),
    .ack0       (ack0),
    .ack1       (ack1),
    .owner      (owner),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model: one transfer record plus the round-robin preference.
  // ---------------------------------------------------------------------------
  bit               m_valid = 1'b0;
  bit               m_active, m_ack, m_err, m_owner, m_we, m_rr;
  logic [REG_W-1:0] m_ri, m_rj;
  int               m_age;
  wire              m_pick = (req0 && req1) ? m_rr : req1;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (reset) begin
      m_active <= 1'b0;
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      m_owner  <= 1'b0;
      m_we     <= 1'b0;
      m_rr     <= 1'b0;
      m_ri     <= '0;
      m_rj     <= '0;
      m_age    <= 0;
    end else if (!m_active) begin
      if (req0 || req1) begin
        m_active <= 1'b1;
        m_owner  <= m_pick;
        m_we     <= m_pick ? we1 : we0;
        m_ri     <= m_pick ? ri1 : ri0;
        m_rj     <= m_pick ? rj1 : rj0;
        m_age    <= 0;
        m_ack    <= 1'b0;
        m_err    <= 1'b0;
      end
    end else if (m_ack) begin
      m_active <= 1'b0;
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      m_rr     <= ~m_owner;
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (m_we ? store_done : load_done) begin
      m_ack <= 1'b1;
`ifdef MEM_TIMEOUT_EN
    end else if (m_age == TB_TIMEOUT) begin
      m_ack <= 1'b1;
      m_err <= 1'b1;
`endif
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_outputs {ls,ss,ack0,ack1,busy,err,owner}",
            {25'd0, load_start, store_start, ack0, ack1, busy, err, owner},
            {25'd0, m_active && m_age == 0 && !m_we,
                    m_active && m_age == 0 && m_we,
                    m_ack && !m_owner, m_ack && m_owner,
                    m_active, m_ack && m_err, m_owner});
      check("cycle_Ri", Ri, m_ri);
      check("cycle_Rj", Rj, m_rj);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after each rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a start, act as the selected FSM with `lat` cycles of
  // latency, then confirm the ack and drop the request. With `rearm` set, the
  // request is raised again in the following IDLE cycle.
  task automatic serve(input bit r, input bit we, input int lat,
                       input bit rearm, input string tag);
    int n = 0;
    while (!(load_start || store_start) && n < 10) begin
      step(1);
      n++;
    end
    check({tag, "_start_seen"}, load_start | store_start, 1);
    check({tag, "_owner"}, owner, r);
    check({tag, "_store_start"}, store_start, we);
    check({tag, "_load_start"}, load_start, !we);
    step(lat);
    if (we) store_done = 1'b1;
    else    load_done  = 1'b1;
    step(1);
    store_done = 1'b0;
    load_done  = 1'b0;
    check({tag, "_ack"}, r ? ack1 : ack0, 1);
    check({tag, "_err"}, err, 0);
    if (r) req1 = 1'b0;
    else   req0 = 1'b0;
    step(1);
    if (rearm) begin
      if (r) req1 = 1'b1;
      else   req0 = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req0 = 0; we0 = 0; ri0 = '0; rj0 = '0;
    req1 = 0; we1 = 0; ri1 = '0; rj1 = '0;
    load_done = 0; store_done = 0;

    // Reset state.
    step(3);
    check("rst_busy", busy, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_starts", {load_start, store_start}, 0);
    check("rst_Ri", Ri, 0);
    check("rst_Rj", Rj, 0);
    check("rst_owner_err", {owner, err}, 0);
    reset = 1'b0;
    step(1);

    // 1: load from requester 0, done 5 cycles after the start pulse.
    req0 = 1; we0 = 0; ri0 = 6'd2; rj0 = 6'd4;
    step(1);
    check("t1_load_start", load_start, 1);
    check("t1_store_start", store_start, 0);
    check("t1_Ri", Ri, 2);
    check("t1_Rj", Rj, 4);
    step(1);
    check("t1_load_start_one_cycle", load_start, 0);
    step(4);
    load_done = 1;
    step(1);
    load_done = 0;
    check("t1_ack0", ack0, 1);
    check("t1_err", err, 0);
    check("t1_Ri_held", Ri, 2);
    check("t1_Rj_held", Rj, 4);
    req0 = 0;
    step(1);
    check("t1_ack0_one_cycle", ack0, 0);
    check("t1_idle", busy, 0);

    // 2: store from requester 1.
    req1 = 1; we1 = 1; ri1 = 6'd3; rj1 = 6'd5;
    step(1);
    check("t2_Ri", Ri, 3);
    check("t2_Rj", Rj, 5);
    serve(1, 1, 3, 0, "t2");

    // 3: both requesting from reset, each re-raised -> grant order 0,1,0,1.
    reset = 1;
    step(1);
    reset = 0;
    req0 = 1; we0 = 0; ri0 = 6'd1; rj0 = 6'd1;
    req1 = 1; we1 = 1; ri1 = 6'd7; rj1 = 6'd9;
    serve(0, 0, 2, 1, "t3a");
    serve(1, 1, 2, 1, "t3b");
    serve(0, 0, 1, 0, "t3c");
    serve(1, 1, 1, 0, "t3d");

    // 4: a done from the other FSM is ignored in WAIT; dones in IDLE do nothing.
    req0 = 1; we0 = 0; ri0 = 6'd5; rj0 = 6'd6;
    step(3);
    store_done = 1;
    step(1);
    store_done = 0;
    check("t4_wrong_done_busy", busy, 1);
    check("t4_wrong_done_no_ack", ack0, 0);
    step(1);
    check("t4_still_waiting", {busy, ack0}, 2'b10);
    load_done = 1;
    step(1);
    load_done = 0;
    check("t4_ack0", ack0, 1);
    req0 = 0;
    step(1);
    load_done = 1; store_done = 1;
    step(1);
    load_done = 0; store_done = 0;
    check("t4_idle_done_no_ack", {ack0, ack1}, 0);
    check("t4_idle_done_busy", busy, 0);
    step(1);
    check("t4_idle_done_no_start", {load_start, store_start, busy}, 0);

    // 5: reset in WAIT aborts; the held req1 is granted first afterwards.
    req1 = 1; we1 = 0; ri1 = 6'd11; rj1 = 6'd12;
    step(3);
    reset = 1;
    step(1);
    reset = 0;
    check("t5_reset_busy", busy, 0);
    check("t5_reset_no_ack", ack1, 0);
    check("t5_reset_Ri", Ri, 0);
    step(1);
    check("t5_regrant_start", load_start, 1);
    check("t5_regrant_owner", owner, 1);
    check("t5_regrant_Ri", Ri, 11);
    step(2);
    load_done = 1;
    step(1);
    load_done = 0;
    check("t5_ack1", ack1, 1);
    req1 = 0;
    step(1);

    // 6: no done ever arrives.
    req0 = 1; we0 = 0; ri0 = 6'd8; rj0 = 6'd9;
    step(1);
    check("t6_start", load_start, 1);
`ifdef MEM_TIMEOUT_EN
    step(8);
    check("t6_before_abort", {busy, ack0}, 2'b10);
    step(1);
    check("t6_abort_ack0", ack0, 1);
    check("t6_abort_err", err, 1);
    req0 = 0;
    step(1);
    load_done = 1;
    step(1);
    load_done = 0;
    check("t6_late_done_ignored", {busy, ack0, err}, 0);
`else
    step(20);
    check("t6_still_busy", busy, 1);
    check("t6_no_ack", {ack0, err}, 0);
    load_done = 1;
    step(1);
    load_done = 0;
    check("t6_ack0", ack0, 1);
    check("t6_err_tied", err, 0);
    req0 = 0;
    step(1);
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
